// File: rtl/receiver_spi_deframer.sv
// SPI byte-stream deframer: rebuilds 4 x 11-bit channels from 8-byte frames, with gap and link timeouts.
// Optional build macro RECEIVER_SPI_DEFRAMER_ERR_CNT_EN adds a saturating frame-error counter output.
//
// state    | meaning
// S_HIGH   | expecting a channel high byte
// S_LOW    | expecting a channel low byte
// S_COMMIT | one cycle, chan_data holds the new frame, frame_valid high
// S_DROP   | one cycle, partial frame discarded, frame_error high
module receiver_spi_deframer #(
  parameter int GAP_TIMEOUT  = 4096,
  parameter int GAP_W        = 12,
  parameter int LINK_TIMEOUT = 1000000,
  parameter int LINK_W       = 20
) (
  input  logic        clk_system,
  input  logic        reset,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_rx_valid,
  output logic [43:0] chan_data,
  output logic        frame_valid,
  output logic        frame_error,
`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        link_ok
);

  typedef enum logic [1:0] {S_HIGH, S_LOW, S_COMMIT, S_DROP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        chan_idx, chan_idx_nxt;
  logic [10:0]       shadow0, shadow1, shadow2;
  logic [2:0]        shadow3_hi;
  logic [GAP_W-1:0]  gap_cnt;
  logic [LINK_W-1:0] link_cnt, link_cnt_inc;
  logic              mid_frame, gap_expire, hi_store, lo_store, commit_load;

  always_comb begin
    state_nxt    = state;
    chan_idx_nxt = chan_idx;
    hi_store     = 1'b0;
    lo_store     = 1'b0;
    commit_load  = 1'b0;
    mid_frame    = (state == S_LOW) || ((state == S_HIGH) && (chan_idx != 2'd0));
    // Fires on the cycle the counter would step onto GAP_TIMEOUT-1.
    gap_expire   = mid_frame && !spi_rx_valid && (gap_cnt == GAP_W'(GAP_TIMEOUT - 2));
    case (state)
      S_HIGH, S_COMMIT, S_DROP: begin
        state_nxt = S_HIGH;
        if (spi_rx_valid) begin
          if (spi_rx_data[7:3] != 5'd0) begin
            state_nxt    = S_DROP;
            chan_idx_nxt = 2'd0;
          end else begin
            hi_store  = 1'b1;
            state_nxt = S_LOW;
          end
        end else if (gap_expire) begin
          state_nxt    = S_DROP;
          chan_idx_nxt = 2'd0;
        end
      end
      S_LOW: begin
        if (spi_rx_valid) begin
          lo_store = 1'b1;
          if (chan_idx == 2'd3) begin
            commit_load  = 1'b1;
            state_nxt    = S_COMMIT;
            chan_idx_nxt = 2'd0;
          end else begin
            chan_idx_nxt = chan_idx + 2'd1;
            state_nxt    = S_HIGH;
          end
        end else if (gap_expire) begin
          state_nxt    = S_DROP;
          chan_idx_nxt = 2'd0;
        end
      end
      default: state_nxt = S_HIGH;
    endcase
  end

  assign link_cnt_inc = (link_cnt == LINK_W'(LINK_TIMEOUT - 1)) ? link_cnt
                                                                 : link_cnt + LINK_W'(1);

  always_ff @(posedge clk_system) begin
    if (reset) begin
      state      <= S_HIGH;
      chan_idx   <= 2'd0;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
      shadow3_hi <= '0;
      chan_data  <= '0;
      gap_cnt    <= '0;
      link_cnt   <= '0;
      link_ok    <= 1'b0;
    end else begin
      state    <= state_nxt;
      chan_idx <= chan_idx_nxt;
      if (hi_store) begin
        case (chan_idx)
          2'd0:    shadow0[10:8] <= spi_rx_data[2:0];
          2'd1:    shadow1[10:8] <= spi_rx_data[2:0];
          2'd2:    shadow2[10:8] <= spi_rx_data[2:0];
          default: shadow3_hi    <= spi_rx_data[2:0];
        endcase
      end
      if (lo_store) begin
        case (chan_idx)
          2'd0:    shadow0[7:0] <= spi_rx_data;
          2'd1:    shadow1[7:0] <= spi_rx_data;
          2'd2:    shadow2[7:0] <= spi_rx_data;
          default: ;
        endcase
      end
      // ch3 low byte is taken straight off the bus so chan_data is valid during S_COMMIT.
      if (commit_load)
        chan_data <= {shadow3_hi, spi_rx_data, shadow2, shadow1, shadow0};
      if (spi_rx_valid || !mid_frame) gap_cnt <= '0;
      else                            gap_cnt <= gap_cnt + GAP_W'(1);
      if (state == S_COMMIT) begin
        link_cnt <= '0;
        link_ok  <= 1'b1;
      end else begin
        link_cnt <= link_cnt_inc;
        if (link_cnt_inc == LINK_W'(LINK_TIMEOUT - 1)) link_ok <= 1'b0;
      end
    end
  end

  assign frame_valid = (state == S_COMMIT);
  assign frame_error = (state == S_DROP);

`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
  always_ff @(posedge clk_system) begin
    if (reset)                                err_count <= 8'h00;
    else if (frame_error && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_receiver_spi_deframer.sv
// Directed self-checking bench for receiver_spi_deframer (short gap/link timeouts).
module tb_receiver_spi_deframer;
  logic        clk_system = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  spi_rx_data = 8'h00;
  logic        spi_rx_valid = 1'b0;
  logic [43:0] chan_data;
  logic        frame_valid, frame_error, link_ok;
`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0;

  receiver_spi_deframer #(.GAP_TIMEOUT(16), .GAP_W(5), .LINK_TIMEOUT(100), .LINK_W(7)) dut (
    .clk_system  (clk_system),
    .reset       (reset),
    .spi_rx_data (spi_rx_data),
    .spi_rx_valid(spi_rx_valid),
    .chan_data   (chan_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
    .err_count   (err_count),
`endif
    .link_ok     (link_ok)
  );

  always #5 clk_system = ~clk_system;

  always @(posedge clk_system) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (frame_valid && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_system);
  endtask

  // Called at a negedge: the strobe is sampled by the next posedge, i.e. in the current state cycle.
  task automatic send_byte(input logic [7:0] b);
    spi_rx_data  = b;
    spi_rx_valid = 1'b1;
    @(negedge clk_system);
    spi_rx_valid = 1'b0;
    spi_rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [43:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte({5'b0, f[i*11+8 +: 3]});
      idle(gap);
      send_byte(f[i*11 +: 8]);
      if (i < 3) idle(gap);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_tests++; if (chan_data !== 44'h0) begin n_fail++; $display("FAIL reset_chan_data got %h want 0", chan_data); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    n_tests++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link_ok got %b want 0", link_ok); end
`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
    n_tests++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count got %h want 0", err_count); end
`endif
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_frame;
    logic [43:0] exp_f;
    int fv0;
    exp_f = {11'h3E8, 11'h7FF, 11'h000, 11'h555};
    fv0 = fv_cnt;
    send_frame(exp_f, 9);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_frame_valid got %b want 1", frame_valid); end
    n_tests++; if (chan_data !== exp_f) begin n_fail++; $display("FAIL basic_chan_data got %h want %h", chan_data, exp_f); end
    n_tests++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL basic_link_in_commit got %b want 0", link_ok); end
    idle(1);
    n_tests++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL basic_link_ok got %b want 1", link_ok); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fv_one_cycle got %b want 0", frame_valid); end
    idle(2);
    n_tests++; if (fv_cnt - fv0 !== 1) begin n_fail++; $display("FAIL basic_fv_pulses got %0d want 1", fv_cnt - fv0); end
  endtask

  task automatic test_bad_high;
    logic [43:0] prev_f, exp_f;
    prev_f = {11'h3E8, 11'h7FF, 11'h000, 11'h555};
    exp_f  = {11'h0AB, 11'h789, 11'h456, 11'h123};
    send_byte(8'h01); idle(2); send_byte(8'h23); idle(2);
    send_byte(8'h08);
    n_tests++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL bad_high_error got %b want 1", frame_error); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bad_high_no_valid got %b want 0", frame_valid); end
    n_tests++; if (chan_data !== prev_f) begin n_fail++; $display("FAIL bad_high_hold got %h want %h", chan_data, prev_f); end
    idle(1);
    n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL bad_high_pulse_len got %b want 0", frame_error); end
    send_frame(exp_f, 3);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL bad_high_recover_valid got %b want 1", frame_valid); end
    n_tests++; if (chan_data !== exp_f) begin n_fail++; $display("FAIL bad_high_recover_data got %h want %h", chan_data, exp_f); end
    idle(1);
  endtask

  task automatic test_gap_timeout;
    int fe0;
    logic [43:0] exp_f;
    fe0 = fe_cnt;
    send_byte(8'h02); idle(1); send_byte(8'h22); idle(1); send_byte(8'h03);
    idle(14);
    n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL gap_early got %b want 0", frame_error); end
    idle(1);
    n_tests++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL gap_expire got %b want 1", frame_error); end
    idle(100);
    n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL gap_idle_errors got %0d want 1", fe_cnt - fe0); end
    // byte landing on the expiry cycle must win
    exp_f = {11'h111, 11'h222, 11'h333, 11'h444};
    fe0 = fe_cnt;
    send_byte(8'h04);
    idle(14);
    send_byte(8'h44);
    idle(14);
    send_byte(8'h03); idle(1); send_byte(8'h33); idle(1);
    send_byte(8'h02); idle(1); send_byte(8'h22); idle(1);
    send_byte(8'h01); idle(1); send_byte(8'h11);
    n_tests++; if (frame_valid !== 1'b1 || chan_data !== exp_f) begin n_fail++;
      $display("FAIL gap_edge_commit got fv=%b %h want fv=1 %h", frame_valid, chan_data, exp_f); end
    idle(2);
    n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL gap_edge_errors got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back;
    logic [43:0] fa, fb;
    int fe0;
    fa = {11'h001, 11'h002, 11'h003, 11'h004};
    fb = {11'h7AA, 11'h655, 11'h5F0, 11'h40F};
    fe0 = fe_cnt;
    send_frame(fa, 0);
    n_tests++; if (frame_valid !== 1'b1 || chan_data !== fa) begin n_fail++;
      $display("FAIL b2b_first got fv=%b %h want fv=1 %h", frame_valid, chan_data, fa); end
    send_frame(fb, 0);
    n_tests++; if (frame_valid !== 1'b1 || chan_data !== fb) begin n_fail++;
      $display("FAIL b2b_second got fv=%b %h want fv=1 %h", frame_valid, chan_data, fb); end
    idle(1);
    n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL b2b_errors got %0d want 0", fe_cnt - fe0); end
    // bad byte during S_DROP drops again
    send_byte(8'h08);
    n_tests++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL drop_first got %b want 1", frame_error); end
    send_byte(8'h10);
    n_tests++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL drop_again got %b want 1", frame_error); end
    send_frame(fa, 0);
    n_tests++; if (frame_valid !== 1'b1 || chan_data !== fa) begin n_fail++;
      $display("FAIL drop_then_commit got fv=%b %h want fv=1 %h", frame_valid, chan_data, fa); end
    idle(1);
  endtask

  task automatic test_link_timeout;
    logic [43:0] f;
    f = {11'h100, 11'h200, 11'h300, 11'h400};
    send_frame(f, 0);
    idle(99);
    n_tests++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL link_before_expiry got %b want 1", link_ok); end
    idle(1);
    n_tests++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL link_expired got %b want 0", link_ok); end
    send_frame(f, 0);
    idle(91);
    send_frame(f, 0);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL link_edge_commit got %b want 1", frame_valid); end
    idle(1);
    n_tests++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL link_edge_keep got %b want 1", link_ok); end
    idle(1);
    n_tests++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL link_edge_keep2 got %b want 1", link_ok); end
  endtask

  task automatic test_reset_mid_frame;
    logic [43:0] f;
    int fe0;
    f = {11'h0F0, 11'h70F, 11'h3C3, 11'h1A5};
    fe0 = fe_cnt;
    send_byte(8'h01); send_byte(8'hA5); send_byte(8'h03); send_byte(8'hC3); send_byte(8'h07);
    reset = 1'b1;
    idle(2);
    n_tests++; if ({chan_data, frame_valid, frame_error, link_ok} !== 47'h0) begin n_fail++;
      $display("FAIL midreset_outputs got %h/%b/%b/%b want 0", chan_data, frame_valid, frame_error, link_ok); end
    reset = 1'b0;
    idle(40);
    n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL midreset_errors got %0d want 0", fe_cnt - fe0); end
    send_frame(f, 1);
    n_tests++; if (frame_valid !== 1'b1 || chan_data !== f) begin n_fail++;
      $display("FAIL midreset_commit got fv=%b %h want fv=1 %h", frame_valid, chan_data, f); end
    idle(1);
  endtask

`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
  task automatic test_err_count;
    n_tests++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL errcnt_start got %h want 00", err_count); end
    repeat (10) send_byte(8'h08);
    idle(1);
    n_tests++; if (err_count !== 8'd10) begin n_fail++; $display("FAIL errcnt_10 got %h want 0a", err_count); end
    repeat (290) send_byte(8'h08);
    idle(2);
    n_tests++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL errcnt_sat got %h want ff", err_count); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic_frame;
    test_bad_high;
    test_gap_timeout;
    test_back_to_back;
    test_link_timeout;
    test_reset_mid_frame;
`ifdef RECEIVER_SPI_DEFRAMER_ERR_CNT_EN
    test_err_count;
`endif
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_error_overlap got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/receiver_spi_deframer.md
Name: receiver_spi_deframer

Overview:
- Receive-side counterpart of the receiver-channel SPI framer: rebuilds 4 × 11-bit control channels from the SPI byte stream.
- Byte order on the wire is ch0..ch3; each channel is sent as a high byte {5'b0, data[10:8]} then a low byte data[7:0], so one frame is 8 bytes.
- Sits behind the SPI slave shift register. Drives the flight controller's channel inputs and its link-loss failsafe flag.

Parameters:
- GAP_TIMEOUT, 4096: max clk_system cycles allowed between bytes inside a frame before the frame is dropped.
- GAP_W, 12: width of the gap counter; must satisfy 2^GAP_W >= GAP_TIMEOUT.
- LINK_TIMEOUT, 1000000: cycles without a committed frame before link_ok deasserts.
- LINK_W, 20: width of the link counter; must satisfy 2^LINK_W >= LINK_TIMEOUT.

Ports:
- clk_system  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_rx_data  in  8  received byte, valid only while spi_rx_valid is high
- spi_rx_valid  in  1  one-cycle strobe per received byte
- chan_data  out  44  {ch3, ch2, ch1, ch0}, 11 bits each, updated atomically per frame
- frame_valid  out  1  one-cycle pulse on the cycle chan_data updates
- frame_error  out  1  one-cycle pulse when a frame is discarded
- link_ok  out  1  high while committed frames keep arriving within LINK_TIMEOUT

Behaviour:
- Reset values: chan_data=0, frame_valid=0, frame_error=0, link_ok=0. Internally: state=S_HIGH, chan_idx=0, shadow registers=0, gap and link counters=0.
- States:
  - S_HIGH: expecting a high byte.
  - S_LOW: expecting a low byte.
  - S_COMMIT: one cycle.
  - S_DROP: one cycle.
- S_HIGH on spi_rx_valid:
  - If spi_rx_data[7:3]!=0: go to S_DROP.
  - Else store data[2:0] as shadow[chan_idx][10:8] and go to S_LOW.
- S_LOW on spi_rx_valid:
  - Store the byte as shadow[chan_idx][7:0].
  - If chan_idx==3: go to S_COMMIT.
  - Else increment chan_idx and go to S_HIGH.
- S_COMMIT: chan_data <= all shadows in one cycle; frame_valid=1; chan_idx <= 0; return to S_HIGH.
- S_DROP: frame_error=1; chan_idx <= 0; shadows untouched; chan_data unchanged; return to S_HIGH.
- A byte arriving during S_COMMIT or S_DROP is processed exactly as an S_HIGH byte for channel 0:
  - Its next state overrides the return to S_HIGH.
  - A bad high byte in that cycle goes to S_DROP again.
- Gap counter:
  - Cleared on every spi_rx_valid.
  - Increments while mid-frame (state S_LOW, or S_HIGH with chan_idx!=0).
  - Held at 0 in S_HIGH with chan_idx==0; there is no timeout while idle.
  - Reaching GAP_TIMEOUT-1 with no spi_rx_valid that cycle: go to S_DROP.
  - A byte arriving on the expiry cycle wins; the timeout does not fire.
- Latency: frame_valid asserts 1 cycle after the strobe carrying the 8th byte. chan_data is valid in that same cycle and held until the next commit.
- frame_valid and frame_error are never high together.
- Link counter:
  - Cleared in S_COMMIT; otherwise increments, saturating at LINK_TIMEOUT-1.
  - link_ok is registered: set the cycle after S_COMMIT, cleared when the counter reaches LINK_TIMEOUT-1.
  - A commit on the expiry cycle keeps link_ok high.
- Reset mid-frame: all state is cleared, a partial frame is lost, and no frame_error pulse is produced.

Optional Feature:
- Macro: RECEIVER_SPI_DEFRAMER_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments on every frame_error pulse and saturates at 8'hFF.
  - Clears when reset is high.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Send bytes 05 55, 00 00, 07 FF, 03 E8 with 10-cycle spacing -> one frame_valid pulse; chan_data = {11'h3E8, 11'h7FF, 11'h000, 11'h555}; link_ok=1 on the next cycle.
- High byte 0x08 for ch1 -> frame_error pulse 1 cycle later; chan_data holds the previous frame; the next 8 good bytes commit normally.
- 3 bytes of a frame then silence (GAP_TIMEOUT=16) -> frame_error pulse exactly 16 cycles after the last strobe. With no bytes sent, no error ever fires.
- Byte strobed on the cycle S_COMMIT is active -> treated as ch0 high byte; the following 7 bytes complete a second frame with no error.
- LINK_TIMEOUT=100 with one frame then silence -> link_ok drops 100 cycles after the commit cycle. Commit on the expiry cycle -> link_ok stays high.
- Assert reset after 5 bytes -> all outputs 0, no frame_error; a fresh 8-byte frame then commits. With ERR_CNT_EN, 300 bad frames -> err_count=8'hFF.
